data_mem: RTL and testbench

- Data-memory responder: the far end of the mem_addr/mem_wdata/mem_en/mem_wr command bus driven by the execute-stage memory command logic.
- Services one load or store at a time, with a configurable number of wait states.
- Returns read data plus a one-cycle completion pulse.
- Provides a stall level that freezes the pipeline while an access is outstanding.

---
 rtl/data_mem_pkg.sv | 6 +
 rtl/data_mem_if.sv | 14 +
 rtl/data_mem_array.sv | 20 ++
 rtl/data_mem.sv | 80 ++++++++
 tb/tb_data_mem.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared FSM states and widths for the data-memory responder
package data_mem_pkg;
   typedef enum logic [1:0] {DMEM_IDLE, DMEM_WAIT, DMEM_RESP} dmem_state_t;
   localparam int DMEM_WORD_W = 32;
   localparam int DMEM_CNT_W = 4;
endpackage

// File: rtl/data_mem_if.sv
// data_mem_if: memory command bus between the execute stage and the data memory
interface data_mem_if;
   import data_mem_pkg::*;
   logic [31:0] mem_addr;
   logic [DMEM_WORD_W-1:0] mem_wdata;
   logic mem_en;
   logic mem_wr;
   logic [DMEM_WORD_W-1:0] mem_rdata;
   logic mem_ready;
   logic mem_stall;
   logic mem_err;
   modport master(output mem_addr, mem_wdata, mem_en, mem_wr, input mem_rdata, mem_ready, mem_stall, mem_err);
   modport slave(input mem_addr, mem_wdata, mem_en, mem_wr, output mem_rdata, mem_ready, mem_stall, mem_err);
endinterface

// File: rtl/data_mem_array.sv
// dmem_array: single-port synchronous word RAM with registered read data, no reset
module dmem_array
   import data_mem_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic clk,
   input  logic we,
   input  logic re,
   input  logic [ADDR_W-1:0] idx,
   input  logic [DMEM_WORD_W-1:0] wdata,
   output logic [DMEM_WORD_W-1:0] rdata
);
   logic [DMEM_WORD_W-1:0] mem [2**ADDR_W];
   // one access per edge: write the word or capture it into the read register
   always_ff @(posedge clk) begin
      if (we) mem[idx] <= wdata;
      if (re) rdata <= mem[idx];
   end
endmodule

// File: rtl/data_mem.sv
// data_mem: wait-state data-memory responder; DMEM_ALIGN_CHECK_EN adds misalignment detection
module data_mem
   import data_mem_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int WAIT_CYCLES = 2
) (
   input logic clk,
   input logic rst,
   data_mem_if.slave bus
);
   dmem_state_t state;
   logic [DMEM_CNT_W-1:0] cnt;
   logic [ADDR_W-1:0] idx;
   logic [DMEM_WORD_W-1:0] wdata;
   logic wr, mis, rd_ok, bad, fire;
   logic [DMEM_WORD_W-1:0] arr_rdata;
   logic unused_addr;
`ifdef DMEM_ALIGN_CHECK_EN
   assign bad = |bus.mem_addr[1:0];
`else
   assign bad = 1'b0;
`endif
   assign unused_addr = &{1'b0, bus.mem_addr[31:ADDR_W+2], bus.mem_addr[1:0]};
   assign fire = (state == DMEM_WAIT) && (cnt == '0);
   assign bus.mem_stall = bus.mem_en & ~bus.mem_ready;
   // rd_ok masks the RAM read register so reset and misaligned loads read as zero
   assign bus.mem_rdata = rd_ok ? arr_rdata : '0;
   dmem_array #(.ADDR_W(ADDR_W)) u_array (
      .clk(clk),
      .we(fire & wr & ~mis),
      .re(fire & ~wr & ~mis),
      .idx(idx),
      .wdata(wdata),
      .rdata(arr_rdata)
   );
   // request FSM: latch on accept, count wait states, pulse ready for one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= DMEM_IDLE;
         cnt <= '0;
         idx <= '0;
         wdata <= '0;
         wr <= 1'b0;
         mis <= 1'b0;
         rd_ok <= 1'b0;
         bus.mem_ready <= 1'b0;
         bus.mem_err <= 1'b0;
      end else begin
         case (state)
            DMEM_IDLE: begin
               bus.mem_ready <= 1'b0;
               bus.mem_err <= 1'b0;
               if (bus.mem_en) begin
                  idx <= bus.mem_addr[ADDR_W+1:2];
                  wdata <= bus.mem_wdata;
                  wr <= bus.mem_wr;
                  mis <= bad;
                  cnt <= DMEM_CNT_W'(WAIT_CYCLES);
                  state <= DMEM_WAIT;
               end
            end
            DMEM_WAIT: begin
               if (cnt != '0) cnt <= cnt - 1'b1;
               else begin
                  state <= DMEM_RESP;
                  bus.mem_ready <= 1'b1;
                  bus.mem_err <= mis;
                  if (!wr) rd_ok <= ~mis;
               end
            end
            default: begin
               bus.mem_ready <= 1'b0;
               bus.mem_err <= 1'b0;
               state <= DMEM_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: scoreboard bench for data_mem with WAIT_CYCLES=2 (d=0) and WAIT_CYCLES=0 (d=1)
module tb_data_mem;
`ifdef DMEM_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif
   typedef struct packed {logic [31:0] rd; logic err;} exp_t;

   logic clk = 1'b0;
   logic rst;
   logic [31:0] addr [2];
   logic [31:0] wdat [2];
   logic en [2];
   logic wr [2];
   logic [31:0] rdata [2];
   logic rdy [2];
   logic stall [2];
   logic err [2];
   logic [31:0] mdl [2][1024];
   logic [31:0] last_rd [2];
   exp_t sb [$];
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   data_mem_if b0();
   data_mem_if b1();
   assign b0.mem_addr = addr[0];
   assign b0.mem_wdata = wdat[0];
   assign b0.mem_en = en[0];
   assign b0.mem_wr = wr[0];
   assign b1.mem_addr = addr[1];
   assign b1.mem_wdata = wdat[1];
   assign b1.mem_en = en[1];
   assign b1.mem_wr = wr[1];
   assign rdata[0] = b0.mem_rdata;
   assign rdy[0] = b0.mem_ready;
   assign stall[0] = b0.mem_stall;
   assign err[0] = b0.mem_err;
   assign rdata[1] = b1.mem_rdata;
   assign rdy[1] = b1.mem_ready;
   assign stall[1] = b1.mem_stall;
   assign err[1] = b1.mem_err;

   data_mem #(.ADDR_W(10), .WAIT_CYCLES(2)) dut0 (.clk(clk), .rst(rst), .bus(b0));
   data_mem #(.ADDR_W(10), .WAIT_CYCLES(0)) dut1 (.clk(clk), .rst(rst), .bus(b1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // drive one request at a negedge, leave mem_en high when ready is seen
   task automatic access(input int d, input logic [31:0] a, input logic [31:0] wd, input logic w,
                         input bit b2b, input bit chg);
      int n, lat, k;
      bit mis;
      exp_t e;
      lat = (d == 0 ? 2 : 0) + 2 + (b2b ? 1 : 0);
      mis = ALIGN && (a[1:0] != 2'b00);
      k = int'(a[11:2]);
      if (w) begin
         if (!mis) mdl[d][k] = wd;
      end else last_rd[d] = mis ? 32'h0 : mdl[d][k];
      e.rd = last_rd[d];
      e.err = mis;
      sb.push_back(e);
      addr[d] = a;
      wdat[d] = wd;
      wr[d] = w;
      en[d] = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (chg && n == 1) begin
            addr[d] = a + 32'd4;
            wr[d] = 1'b1;
            wdat[d] = 32'hBAD0BAD0;
         end
         if (!rdy[d]) chk("stall_wait", 32'(stall[d]), 32'd1);
      end while (!rdy[d] && n < 40);
      chk("latency", 32'(n), 32'(lat));
      e = sb.pop_front();
      chk("rdata", rdata[d], e.rd);
      chk("err", 32'(err[d]), 32'(e.err));
      chk("stall_ready", 32'(stall[d]), 32'd0);
   endtask

   task automatic idle(input int d);
      en[d] = 1'b0;
      wr[d] = 1'b0;
      @(negedge clk);
      chk("ready_pulse", 32'(rdy[d]), 32'd0);
      chk("err_pulse", 32'(err[d]), 32'd0);
      chk("stall_idle", 32'(stall[d]), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         addr[d] = '0;
         wdat[d] = '0;
         en[d] = 1'b0;
         wr[d] = 1'b0;
         last_rd[d] = '0;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_rdata", rdata[d], 32'h0);
         chk("rst_ready", 32'(rdy[d]), 32'd0);
         chk("rst_err", 32'(err[d]), 32'd0);
         chk("rst_stall", 32'(stall[d]), 32'd0);
      end
      access(0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0); idle(0);
      access(0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0); idle(0);
      access(0, 32'h24, 32'h0, 1'b1, 1'b0, 1'b0); idle(0);
      access(0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0); idle(0);
      access(1, 32'h0, 32'h11, 1'b1, 1'b0, 1'b0); idle(1);
      access(1, 32'h4, 32'h22, 1'b1, 1'b0, 1'b0); idle(1);
      addr[0] = 32'h10;
      wdat[0] = 32'hDEADBEEF;
      wr[0] = 1'b1;
      en[0] = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_rdata", rdata[0], 32'h0);
      chk("midrst_ready", 32'(rdy[0]), 32'd0);
      chk("midrst_err", 32'(err[0]), 32'd0);
      en[0] = 1'b0;
      wr[0] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      access(0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0); idle(0);
      access(0, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0); idle(0);
      access(0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0); idle(0);
      access(1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      access(1, 32'h4, 32'h0, 1'b0, 1'b1, 1'b0); idle(1);
      access(1, 32'h8, 32'h33, 1'b1, 1'b0, 1'b0); idle(1);
      chk("rdata_held", rdata[1], 32'h22);
      access(0, 32'h1000, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0); idle(0);
      access(0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0); idle(0);
      access(0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b1); idle(0);
      access(0, 32'h24, 32'h0, 1'b0, 1'b0, 1'b0); idle(0);
      access(0, 32'h13, 32'h12345678, 1'b1, 1'b0, 1'b0); idle(0);
      access(0, 32'h13, 32'h0, 1'b0, 1'b0, 1'b0); idle(0);
      access(0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0); idle(0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
